l2_cache_read_stage: RTL and testbench
======================================

# l2_cache_read_stage

Third stage of the L2 cache pipeline, directly downstream of the tag stage. Compares the tags and valid bits read by the tag stage to detect a hit, computes the tag, dirty and LRU updates and feeds them back to the tag stage in the same cycle. Reads the line data SRAM at the hit or victim way and hands request, line data, hit and writeback information to the update stage one cycle later.

## Interface
- WAYS, 8, associativity (power of two)
- SETS, 256, sets per way (power of two)
- TAG_WIDTH, 18, address tag bits
- LINE_BITS, 512, cache line width
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- l2t_request_valid / l2t_request  in  1 / l2req_packet_t  request from tag stage; fields used: packet_type (LOAD, STORE, FLUSH, INVALIDATE), address.tag, address.set_idx
- l2t_valid[WAYS], l2t_tag[WAYS], l2t_dirty[WAYS]  in  1 / TAG_WIDTH / 1  per-way metadata for the request's set
- l2t_l2_fill / l2t_fill_way  in  1 / log2(WAYS)  request is a memory fill; victim way chosen by LRU
- l2t_data_from_memory  in  LINE_BITS  fill data, passed through
- l2t_restarted_flush  in  1  passed through
- l2u_write_en / l2u_write_addr / l2u_write_data  in  1 / log2(WAYS*SETS) / LINE_BITS  data SRAM write port, driven by update stage
- l2r_update_dirty_en / _set / _value  out  WAYS / log2(SETS) / 1  dirty flag write to tag stage
- l2r_update_tag_en / _set / _valid / _value  out  WAYS / log2(SETS) / 1 / TAG_WIDTH  tag write to tag stage
- l2r_update_lru_en / l2r_update_lru_hit_way  out  1 / log2(WAYS)  LRU touch
- l2r_request_valid, l2r_request, l2r_data, l2r_cache_hit, l2r_hit_way, l2r_l2_fill, l2r_restarted_flush, l2r_data_from_memory, l2r_needs_writeback, l2r_writeback_tag  out  registered results to update stage (l2r_data = SRAM line, LINE_BITS)
- l2r_perf_l2_hit / l2r_perf_l2_miss  out  1 / 1  one-cycle event pulses

## Operation
- Way hit: hit[w] = l2t_valid[w] && l2t_tag[w] == address.tag; cache_hit = OR of hit; hit_way = encoded index. More than one hit per request is an assertion failure.
- Data SRAM: WAYS*SETS entries x LINE_BITS, 1r1w, address {way, set_idx}. Read way = l2t_fill_way on fill, else hit_way. Read enabled on l2t_request_valid. A write to the same address in the same cycle returns the new data.
- Feedback updates, combinational, all zero unless l2t_request_valid; _set always = address.set_idx:
  - Fill: tag_en[fill_way], valid=1, value=address.tag; dirty_en[fill_way], value = (type==STORE); lru_en=1, way=fill_way.
  - Non-fill hit: LOAD -> lru only. STORE -> dirty_en[hit_way], value 1; lru. FLUSH -> dirty_en[hit_way], value 0; no lru. INVALIDATE -> tag_en[hit_way], valid 0; dirty_en[hit_way], value 0; no lru.
  - Non-fill miss: no updates; update stage handles memory request.
- Writeback: needs_writeback = (fill && l2t_valid[fill_way] && l2t_dirty[fill_way]) || (FLUSH && hit && l2t_dirty[hit_way]). writeback_tag = fill ? l2t_tag[fill_way] : address.tag. Writeback data is l2r_data.
- Perf: hit pulse = valid && !fill && hit on LOAD/STORE; miss pulse = valid && !fill && !hit on LOAD/STORE.

## Timing
- Feedback update outputs: same cycle as l2t inputs (tag stage captures them at the next edge).
- All l2r_* pipeline outputs and perf pulses: registered, latency 1 cycle; l2r_data from SRAM at same edge.
- No stall, no backpressure: one request per cycle, every cycle.
- Reset: l2r_request_valid, l2r_cache_hit, l2r_needs_writeback, l2r_l2_fill, l2r_restarted_flush, perf pulses = 0. Wide payload (l2r_request, l2r_data, l2r_data_from_memory, l2r_writeback_tag, l2r_hit_way) not reset; meaningful only with l2r_request_valid. Reset mid-request drops it; SRAM contents are not cleared.
- Back-to-back same set: a STORE at cycle N and LOAD at N+1 rely on tag-stage bypass; this block adds none beyond the SRAM write bypass.

## Test plan
- Fill LOAD to set 5, fill_way 3, way 3 invalid -> tag_en=8'h08, valid=1, dirty value 0, lru way 3; next cycle l2r_needs_writeback=0.
- LOAD, set 5, tag 0x123 valid in way 3 -> l2r_cache_hit=1, l2r_hit_way=3, perf hit=1, lru way 3, no tag/dirty enables; l2r_data = line at {3,5}.
- STORE hit way 2 set 9 -> dirty_en=8'h04, value 1; then FLUSH same line with dirty=1 -> dirty_en=8'h04, value 0, needs_writeback=1, writeback_tag = request tag.
- Fill into way 6 holding valid dirty tag 0x0AB -> needs_writeback=1, writeback_tag=0x0AB, l2r_data = old line of way 6.
- INVALIDATE hit way 1 -> tag_en=8'h02, valid=0, lru_en=0; INVALIDATE miss -> all enables 0.
- Update-stage write to {4,7} in same cycle as read of {4,7} -> l2r_data equals written data; reset asserted during valid request -> l2r_request_valid=0 next cycle.

Source files
------------

// File: rtl/l2_cache_read_stage.sv
// L2 cache read stage: hit detection, tag/dirty/LRU feedback to the tag stage,
// line data SRAM read and registered hand-off to the update stage.

package l2_cache_read_stage_pkg;
    localparam int L2_TAG_WIDTH     = 18;
    localparam int L2_SET_IDX_WIDTH = 8;
    localparam int L2_OFFSET_WIDTH  = 6;

    typedef enum logic [1:0] {
        L2REQ_LOAD       = 2'd0,
        L2REQ_STORE      = 2'd1,
        L2REQ_FLUSH      = 2'd2,
        L2REQ_INVALIDATE = 2'd3
    } l2req_packet_type_t;

    typedef struct packed {
        logic [L2_TAG_WIDTH-1:0]     tag;
        logic [L2_SET_IDX_WIDTH-1:0] set_idx;
        logic [L2_OFFSET_WIDTH-1:0]  offset;
    } l2_addr_t;

    typedef struct packed {
        l2req_packet_type_t packet_type;
        logic [3:0]         id;
        l2_addr_t           address;
    } l2req_packet_t;
endpackage

module l2_cache_read_stage
    import l2_cache_read_stage_pkg::*;
#(
    parameter int WAYS      = 8,
    parameter int SETS      = 256,
    parameter int TAG_WIDTH = L2_TAG_WIDTH,
    parameter int LINE_BITS = 512,
    localparam int WAY_IDX_WIDTH   = $clog2(WAYS),
    localparam int SET_IDX_WIDTH   = $clog2(SETS),
    localparam int DATA_ADDR_WIDTH = WAY_IDX_WIDTH + SET_IDX_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       l2t_request_valid,
    input  l2req_packet_t              l2t_request,
    input  logic [WAYS-1:0]            l2t_valid,
    input  logic [TAG_WIDTH-1:0]       l2t_tag [WAYS],
    input  logic [WAYS-1:0]            l2t_dirty,
    input  logic                       l2t_l2_fill,
    input  logic [WAY_IDX_WIDTH-1:0]   l2t_fill_way,
    input  logic [LINE_BITS-1:0]       l2t_data_from_memory,
    input  logic                       l2t_restarted_flush,

    input  logic                       l2u_write_en,
    input  logic [DATA_ADDR_WIDTH-1:0] l2u_write_addr,
    input  logic [LINE_BITS-1:0]       l2u_write_data,

    output logic [WAYS-1:0]            l2r_update_dirty_en,
    output logic [SET_IDX_WIDTH-1:0]   l2r_update_dirty_set,
    output logic                       l2r_update_dirty_value,
    output logic [WAYS-1:0]            l2r_update_tag_en,
    output logic [SET_IDX_WIDTH-1:0]   l2r_update_tag_set,
    output logic                       l2r_update_tag_valid,
    output logic [TAG_WIDTH-1:0]       l2r_update_tag_value,
    output logic                       l2r_update_lru_en,
    output logic [WAY_IDX_WIDTH-1:0]   l2r_update_lru_hit_way,

    output logic                       l2r_request_valid,
    output l2req_packet_t              l2r_request,
    output logic [LINE_BITS-1:0]       l2r_data,
    output logic                       l2r_cache_hit,
    output logic [WAY_IDX_WIDTH-1:0]   l2r_hit_way,
    output logic                       l2r_l2_fill,
    output logic                       l2r_restarted_flush,
    output logic [LINE_BITS-1:0]       l2r_data_from_memory,
    output logic                       l2r_needs_writeback,
    output logic [TAG_WIDTH-1:0]       l2r_writeback_tag,
    output logic                       l2r_perf_l2_hit,
    output logic                       l2r_perf_l2_miss
);

    logic [WAYS-1:0]            way_hit;
    logic                       cache_hit;
    logic [WAY_IDX_WIDTH-1:0]   hit_way;
    logic                       is_load;
    logic                       is_store;
    logic                       is_flush;
    logic                       needs_writeback;
    logic [TAG_WIDTH-1:0]       writeback_tag;
    logic [WAY_IDX_WIDTH-1:0]   read_way;
    logic [DATA_ADDR_WIDTH-1:0] read_addr;
    logic                       load_or_store;

    logic [LINE_BITS-1:0] data_sram [WAYS*SETS];

    assign is_load       = l2t_request.packet_type == L2REQ_LOAD;
    assign is_store      = l2t_request.packet_type == L2REQ_STORE;
    assign is_flush      = l2t_request.packet_type == L2REQ_FLUSH;
    assign load_or_store = is_load || is_store;

    // Compare every way's tag against the request and encode the matching way.
    always_comb begin
        way_hit = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = l2t_valid[w] && (l2t_tag[w] == l2t_request.address.tag);
            if (way_hit[w])
                hit_way = WAY_IDX_WIDTH'(w);
        end
    end

    assign cache_hit = |way_hit;

    // A fill always targets the LRU victim; everything else reads the hit way.
    assign read_way  = l2t_l2_fill ? l2t_fill_way : hit_way;
    assign read_addr = {read_way, l2t_request.address.set_idx};

    assign l2r_update_dirty_set = l2t_request.address.set_idx;
    assign l2r_update_tag_set   = l2t_request.address.set_idx;

    // Metadata feedback to the tag stage, captured there at the next edge.
    always_comb begin
        l2r_update_dirty_en    = '0;
        l2r_update_dirty_value = 1'b0;
        l2r_update_tag_en      = '0;
        l2r_update_tag_valid   = 1'b0;
        l2r_update_tag_value   = '0;
        l2r_update_lru_en      = 1'b0;
        l2r_update_lru_hit_way = '0;
        if (l2t_request_valid) begin
            if (l2t_l2_fill) begin
                l2r_update_tag_en[l2t_fill_way]   = 1'b1;
                l2r_update_tag_valid              = 1'b1;
                l2r_update_tag_value              = l2t_request.address.tag;
                l2r_update_dirty_en[l2t_fill_way] = 1'b1;
                l2r_update_dirty_value            = is_store;
                l2r_update_lru_en                 = 1'b1;
                l2r_update_lru_hit_way            = l2t_fill_way;
            end else if (cache_hit) begin
                case (l2t_request.packet_type)
                    L2REQ_LOAD: begin
                        l2r_update_lru_en      = 1'b1;
                        l2r_update_lru_hit_way = hit_way;
                    end
                    L2REQ_STORE: begin
                        l2r_update_dirty_en[hit_way] = 1'b1;
                        l2r_update_dirty_value       = 1'b1;
                        l2r_update_lru_en            = 1'b1;
                        l2r_update_lru_hit_way       = hit_way;
                    end
                    L2REQ_FLUSH: begin
                        l2r_update_dirty_en[hit_way] = 1'b1;
                        l2r_update_dirty_value       = 1'b0;
                    end
                    L2REQ_INVALIDATE: begin
                        l2r_update_tag_en[hit_way]   = 1'b1;
                        l2r_update_tag_valid         = 1'b0;
                        l2r_update_dirty_en[hit_way] = 1'b1;
                        l2r_update_dirty_value       = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Dirty victims on fills and dirty flushed lines must go back to memory.
    always_comb begin
        if (l2t_l2_fill) begin
            needs_writeback = l2t_valid[l2t_fill_way] && l2t_dirty[l2t_fill_way];
            writeback_tag   = l2t_tag[l2t_fill_way];
        end else begin
            needs_writeback = is_flush && cache_hit && l2t_dirty[hit_way];
            writeback_tag   = l2t_request.address.tag;
        end
    end

    // Data SRAM write port owned by the update stage.
    always_ff @(posedge clk) begin
        if (l2u_write_en)
            data_sram[l2u_write_addr] <= l2u_write_data;
    end

    // Data SRAM read, forwarding a same-cycle write to the same line.
    always_ff @(posedge clk) begin
        if (l2t_request_valid) begin
            if (l2u_write_en && (l2u_write_addr == read_addr))
                l2r_data <= l2u_write_data;
            else
                l2r_data <= data_sram[read_addr];
        end
    end

    // Control flags to the update stage and perf pulses; cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            l2r_request_valid   <= 1'b0;
            l2r_cache_hit       <= 1'b0;
            l2r_l2_fill         <= 1'b0;
            l2r_restarted_flush <= 1'b0;
            l2r_needs_writeback <= 1'b0;
            l2r_perf_l2_hit     <= 1'b0;
            l2r_perf_l2_miss    <= 1'b0;
        end else begin
            l2r_request_valid   <= l2t_request_valid;
            l2r_cache_hit       <= l2t_request_valid && cache_hit;
            l2r_l2_fill         <= l2t_request_valid && l2t_l2_fill;
            l2r_restarted_flush <= l2t_request_valid && l2t_restarted_flush;
            l2r_needs_writeback <= l2t_request_valid && needs_writeback;
            l2r_perf_l2_hit     <= l2t_request_valid && !l2t_l2_fill && cache_hit && load_or_store;
            l2r_perf_l2_miss    <= l2t_request_valid && !l2t_l2_fill && !cache_hit && load_or_store;
        end
    end

    // Wide payload registers; only meaningful alongside l2r_request_valid.
    always_ff @(posedge clk) begin
        l2r_request          <= l2t_request;
        l2r_hit_way          <= hit_way;
        l2r_data_from_memory <= l2t_data_from_memory;
        l2r_writeback_tag    <= writeback_tag;
    end

    // The tag stage must never present the same tag valid in two ways.
    assert property (@(posedge clk) disable iff (reset)
        l2t_request_valid |-> $onehot0(way_hit));

endmodule

// File: tb/tb_l2_cache_read_stage.sv
// Bench for l2_cache_read_stage: directed scenarios followed by random traffic
// checked against a rule-level reference model and a line-data memory model.

module tb_l2_cache_read_stage;
    import l2_cache_read_stage_pkg::*;

    localparam int WAYS = 8;
    localparam int TW   = 18;
    localparam int LB   = 512;
    localparam int WIW  = 3;
    localparam int SIW  = 8;
    localparam int AW   = WIW + SIW;

    logic              clk;
    logic              reset;
    logic              l2t_request_valid;
    l2req_packet_t     l2t_request;
    logic [WAYS-1:0]   l2t_valid;
    logic [TW-1:0]     l2t_tag [WAYS];
    logic [WAYS-1:0]   l2t_dirty;
    logic              l2t_l2_fill;
    logic [WIW-1:0]    l2t_fill_way;
    logic [LB-1:0]     l2t_data_from_memory;
    logic              l2t_restarted_flush;
    logic              l2u_write_en;
    logic [AW-1:0]     l2u_write_addr;
    logic [LB-1:0]     l2u_write_data;
    logic [WAYS-1:0]   l2r_update_dirty_en;
    logic [SIW-1:0]    l2r_update_dirty_set;
    logic              l2r_update_dirty_value;
    logic [WAYS-1:0]   l2r_update_tag_en;
    logic [SIW-1:0]    l2r_update_tag_set;
    logic              l2r_update_tag_valid;
    logic [TW-1:0]     l2r_update_tag_value;
    logic              l2r_update_lru_en;
    logic [WIW-1:0]    l2r_update_lru_hit_way;
    logic              l2r_request_valid;
    l2req_packet_t     l2r_request;
    logic [LB-1:0]     l2r_data;
    logic              l2r_cache_hit;
    logic [WIW-1:0]    l2r_hit_way;
    logic              l2r_l2_fill;
    logic              l2r_restarted_flush;
    logic [LB-1:0]     l2r_data_from_memory;
    logic              l2r_needs_writeback;
    logic [TW-1:0]     l2r_writeback_tag;
    logic              l2r_perf_l2_hit;
    logic              l2r_perf_l2_miss;

    l2_cache_read_stage dut (
        .clk(clk), .reset(reset),
        .l2t_request_valid(l2t_request_valid), .l2t_request(l2t_request),
        .l2t_valid(l2t_valid), .l2t_tag(l2t_tag), .l2t_dirty(l2t_dirty),
        .l2t_l2_fill(l2t_l2_fill), .l2t_fill_way(l2t_fill_way),
        .l2t_data_from_memory(l2t_data_from_memory), .l2t_restarted_flush(l2t_restarted_flush),
        .l2u_write_en(l2u_write_en), .l2u_write_addr(l2u_write_addr), .l2u_write_data(l2u_write_data),
        .l2r_update_dirty_en(l2r_update_dirty_en), .l2r_update_dirty_set(l2r_update_dirty_set),
        .l2r_update_dirty_value(l2r_update_dirty_value),
        .l2r_update_tag_en(l2r_update_tag_en), .l2r_update_tag_set(l2r_update_tag_set),
        .l2r_update_tag_valid(l2r_update_tag_valid), .l2r_update_tag_value(l2r_update_tag_value),
        .l2r_update_lru_en(l2r_update_lru_en), .l2r_update_lru_hit_way(l2r_update_lru_hit_way),
        .l2r_request_valid(l2r_request_valid), .l2r_request(l2r_request), .l2r_data(l2r_data),
        .l2r_cache_hit(l2r_cache_hit), .l2r_hit_way(l2r_hit_way), .l2r_l2_fill(l2r_l2_fill),
        .l2r_restarted_flush(l2r_restarted_flush), .l2r_data_from_memory(l2r_data_from_memory),
        .l2r_needs_writeback(l2r_needs_writeback), .l2r_writeback_tag(l2r_writeback_tag),
        .l2r_perf_l2_hit(l2r_perf_l2_hit), .l2r_perf_l2_miss(l2r_perf_l2_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // stimulus for the current cycle
    logic               s_reset, s_valid, s_fill, s_rflush, s_wen;
    l2req_packet_type_t s_type;
    logic [TW-1:0]      s_tag;
    logic [SIW-1:0]     s_set;
    logic [5:0]         s_off;
    logic [3:0]         s_id;
    logic [WIW-1:0]     s_fill_way;
    logic [WAYS-1:0]    s_vld, s_dirty;
    logic [TW-1:0]      s_tags [WAYS];
    logic [LB-1:0]      s_dfm, s_wdata;
    logic [AW-1:0]      s_waddr;

    // expectations for the registered outputs of the previous cycle
    bit                 p_check = 0;
    logic               p_reset, p_valid, p_hit, p_fill, p_rflush, p_wb, p_perf_hit, p_perf_miss, p_data_known;
    logic [WIW-1:0]     p_hit_way;
    logic [TW-1:0]      p_wb_tag;
    logic [LB-1:0]      p_data, p_dfm;
    l2req_packet_t      p_req;

    logic [LB-1:0]      mem_model [int];
    logic [LB-1:0]      saved_line;

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] v;
        for (int i = 0; i < LB/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // index of the way holding the requested tag, or -1 on a miss
    function automatic int find_hit();
        for (int w = 0; w < WAYS; w++)
            if (s_vld[w] && s_tags[w] == s_tag) return w;
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [LB-1:0] observed, input logic [LB-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        reset                           = s_reset;
        l2t_request_valid               = s_valid;
        l2t_request.packet_type         = s_type;
        l2t_request.id                  = s_id;
        l2t_request.address.tag         = s_tag;
        l2t_request.address.set_idx     = s_set;
        l2t_request.address.offset      = s_off;
        l2t_valid                       = s_vld;
        l2t_dirty                       = s_dirty;
        for (int w = 0; w < WAYS; w++) l2t_tag[w] = s_tags[w];
        l2t_l2_fill                     = s_fill;
        l2t_fill_way                    = s_fill_way;
        l2t_data_from_memory            = s_dfm;
        l2t_restarted_flush             = s_rflush;
        l2u_write_en                    = s_wen;
        l2u_write_addr                  = s_waddr;
        l2u_write_data                  = s_wdata;
    endtask

    // feedback outputs derived directly from the request rules
    task automatic checkComb();
        int h = find_hit();
        logic [WAYS-1:0] e_tag_en = '0, e_dirty_en = '0;
        logic e_tag_valid = 0, e_dirty_val = 0, e_lru = 0;
        logic [WIW-1:0] e_lru_way = '0;
        if (s_valid && s_fill) begin
            e_tag_en    = WAYS'(1) << s_fill_way;
            e_dirty_en  = e_tag_en;
            e_tag_valid = 1;
            e_dirty_val = (s_type == L2REQ_STORE);
            e_lru       = 1;
            e_lru_way   = s_fill_way;
        end else if (s_valid && h >= 0) begin
            e_lru_way  = WIW'(h);
            e_lru      = (s_type == L2REQ_LOAD) || (s_type == L2REQ_STORE);
            e_dirty_en = (s_type == L2REQ_LOAD) ? '0 : (WAYS'(1) << h);
            e_tag_en   = (s_type == L2REQ_INVALIDATE) ? (WAYS'(1) << h) : '0;
            e_dirty_val = (s_type == L2REQ_STORE);
        end
        checkOutput("tag_en", l2r_update_tag_en, e_tag_en);
        checkOutput("dirty_en", l2r_update_dirty_en, e_dirty_en);
        checkOutput("lru_en", l2r_update_lru_en, e_lru);
        if (s_valid) begin
            checkOutput("dirty_set", l2r_update_dirty_set, s_set);
            checkOutput("tag_set", l2r_update_tag_set, s_set);
        end
        if (e_tag_en != 0) checkOutput("tag_valid", l2r_update_tag_valid, e_tag_valid);
        if (e_tag_valid) checkOutput("tag_value", l2r_update_tag_value, s_tag);
        if (e_dirty_en != 0) checkOutput("dirty_value", l2r_update_dirty_value, e_dirty_val);
        if (e_lru) checkOutput("lru_way", l2r_update_lru_hit_way, e_lru_way);
    endtask

    task automatic predict();
        int h = find_hit();
        int raddr;
        logic ls = (s_type == L2REQ_LOAD) || (s_type == L2REQ_STORE);
        p_check     = 1;
        p_reset     = s_reset;
        p_valid     = s_valid && !s_reset;
        p_hit       = (h >= 0);
        p_hit_way   = WIW'(h < 0 ? 0 : h);
        p_fill      = s_fill;
        p_rflush    = s_rflush;
        p_dfm       = s_dfm;
        p_req       = l2t_request;
        p_perf_hit  = p_valid && !s_fill && (h >= 0) && ls;
        p_perf_miss = p_valid && !s_fill && (h < 0) && ls;
        if (s_fill) begin
            p_wb     = s_vld[s_fill_way] && s_dirty[s_fill_way];
            p_wb_tag = s_tags[s_fill_way];
        end else begin
            p_wb     = (s_type == L2REQ_FLUSH) && (h >= 0) && s_dirty[p_hit_way];
            p_wb_tag = s_tag;
        end
        raddr        = int'({(s_fill ? s_fill_way : p_hit_way), s_set});
        p_data_known = p_valid && (s_fill || h >= 0) && (mem_model.exists(raddr) || (s_wen && int'(s_waddr) == raddr));
        if (s_wen && int'(s_waddr) == raddr) p_data = s_wdata;
        else if (mem_model.exists(raddr)) p_data = mem_model[raddr];
        if (s_wen) mem_model[int'(s_waddr)] = s_wdata;
    endtask

    task automatic checkRegistered();
        checkOutput("request_valid", l2r_request_valid, p_valid);
        checkOutput("perf_hit", l2r_perf_l2_hit, p_perf_hit);
        checkOutput("perf_miss", l2r_perf_l2_miss, p_perf_miss);
        if (p_reset) begin
            checkOutput("rst_cache_hit", l2r_cache_hit, 1'b0);
            checkOutput("rst_needs_wb", l2r_needs_writeback, 1'b0);
            checkOutput("rst_fill", l2r_l2_fill, 1'b0);
            checkOutput("rst_rflush", l2r_restarted_flush, 1'b0);
        end
        if (p_valid) begin
            checkOutput("cache_hit", l2r_cache_hit, p_hit);
            checkOutput("l2_fill", l2r_l2_fill, p_fill);
            checkOutput("restarted_flush", l2r_restarted_flush, p_rflush);
            checkOutput("needs_writeback", l2r_needs_writeback, p_wb);
            checkOutput("writeback_tag", l2r_writeback_tag, p_wb_tag);
            checkOutput("data_from_memory", l2r_data_from_memory, p_dfm);
            checkOutput("request", l2r_request, p_req);
            if (p_hit) checkOutput("hit_way", l2r_hit_way, p_hit_way);
            if (p_data_known) checkOutput("data", l2r_data, p_data);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (p_check) checkRegistered();
        applyStimulus();
        #1;
        checkComb();
        predict();
    endtask

    task automatic metaBase();
        s_vld   = '0;
        s_dirty = '0;
        for (int w = 0; w < WAYS; w++) s_tags[w] = TW'(32'h20000 + w * 32'h1111);
    endtask

    task automatic idle();
        metaBase();
        s_reset = 0; s_valid = 0; s_fill = 0; s_fill_way = '0; s_wen = 0; s_rflush = 0;
        s_type = L2REQ_LOAD; s_tag = '0; s_set = '0; s_off = '0; s_id = '0;
        s_waddr = '0; s_wdata = '0; s_dfm = '0;
    endtask

    task automatic randomRequest();
        logic [TW-1:0] base = TW'($urandom);
        int h;
        s_reset = 0;
        s_valid = ($urandom_range(0, 7) != 0);
        s_set   = SIW'($urandom_range(0, 15));
        s_off   = 6'($urandom);
        s_id    = 4'($urandom);
        for (int w = 0; w < WAYS; w++) s_tags[w] = TW'(base + w * 32'h1111);
        s_vld      = WAYS'($urandom);
        s_dirty    = WAYS'($urandom);
        s_type     = l2req_packet_type_t'($urandom_range(0, 3));
        s_fill     = ($urandom_range(0, 3) == 0);
        s_fill_way = WIW'($urandom_range(0, 7));
        if (s_fill || $urandom_range(0, 1) == 0) s_tag = TW'(base + 32'h8888);
        else s_tag = s_tags[$urandom_range(0, 7)];
        s_dfm    = rand_line();
        s_rflush = 1'($urandom);
        s_wen    = ($urandom_range(0, 3) == 0);
        s_waddr  = {WIW'($urandom_range(0, 7)), SIW'($urandom_range(0, 15))};
        h = find_hit();
        if ($urandom_range(0, 2) == 0)
            s_waddr = {(s_fill ? s_fill_way : WIW'(h < 0 ? 0 : h)), s_set};
        s_wdata  = rand_line();
    endtask

    initial begin
        idle();
        s_reset = 1;
        applyStimulus();
        step();
        step();
        idle();
        step();

        // preload lines for sets 0..15 through the update-stage write port
        for (int st = 0; st < 16; st++) begin
            for (int w = 0; w < WAYS; w++) begin
                idle();
                s_wen   = 1;
                s_waddr = {WIW'(w), SIW'(st)};
                s_wdata = rand_line();
                step();
            end
        end

        // fill LOAD into invalid way 3 of set 5
        idle(); s_valid = 1; s_type = L2REQ_LOAD; s_tag = 18'h123; s_set = 8'd5;
        s_fill = 1; s_fill_way = 3'd3;
        step();
        checkOutput("tp_fill_tag_en", l2r_update_tag_en, 8'h08);
        checkOutput("tp_fill_lru_way", l2r_update_lru_hit_way, 3'd3);

        // LOAD hit on way 3 of set 5
        idle(); s_tags[3] = 18'h123; s_vld[3] = 1; s_valid = 1; s_type = L2REQ_LOAD;
        s_tag = 18'h123; s_set = 8'd5;
        step();
        checkOutput("tp_fill_no_wb", l2r_needs_writeback, 1'b0);
        checkOutput("tp_load_lru_way", l2r_update_lru_hit_way, 3'd3);

        // STORE hit on way 2 of set 9
        idle(); s_tags[2] = 18'h2A5A; s_vld[2] = 1; s_valid = 1; s_type = L2REQ_STORE;
        s_tag = 18'h2A5A; s_set = 8'd9;
        step();
        checkOutput("tp_load_hit", l2r_cache_hit, 1'b1);
        checkOutput("tp_load_hit_way", l2r_hit_way, 3'd3);
        checkOutput("tp_load_data", l2r_data, mem_model[int'({3'd3, 8'd5})]);
        checkOutput("tp_store_dirty_en", l2r_update_dirty_en, 8'h04);

        // FLUSH of the now dirty line
        s_type = L2REQ_FLUSH; s_dirty[2] = 1;
        step();
        checkOutput("tp_flush_dirty_en", l2r_update_dirty_en, 8'h04);
        checkOutput("tp_flush_dirty_val", l2r_update_dirty_value, 1'b0);

        // fill evicting dirty tag 0x0AB from way 6 of set 11
        idle(); s_vld = '1; s_tags[6] = 18'h0AB; s_dirty[6] = 1; s_valid = 1;
        s_type = L2REQ_LOAD; s_tag = 18'h3FF; s_set = 8'd11; s_fill = 1; s_fill_way = 3'd6;
        saved_line = mem_model[int'({3'd6, 8'd11})];
        step();
        checkOutput("tp_flush_wb", l2r_needs_writeback, 1'b1);
        checkOutput("tp_flush_wb_tag", l2r_writeback_tag, 18'h2A5A);

        // INVALIDATE hit on way 1
        idle(); s_tags[1] = 18'h1357; s_vld[1] = 1; s_valid = 1; s_type = L2REQ_INVALIDATE;
        s_tag = 18'h1357; s_set = 8'd12;
        step();
        checkOutput("tp_evict_wb", l2r_needs_writeback, 1'b1);
        checkOutput("tp_evict_wb_tag", l2r_writeback_tag, 18'h0AB);
        checkOutput("tp_evict_data", l2r_data, saved_line);
        checkOutput("tp_inval_tag_en", l2r_update_tag_en, 8'h02);
        checkOutput("tp_inval_lru_en", l2r_update_lru_en, 1'b0);

        // INVALIDATE miss
        s_tag = 18'h1358;
        step();
        checkOutput("tp_inval_miss_en", {l2r_update_tag_en, l2r_update_dirty_en, l2r_update_lru_en}, 17'h0);

        // same-cycle write and read of line {4,7}
        idle(); s_tags[4] = 18'h777; s_vld[4] = 1; s_valid = 1; s_type = L2REQ_LOAD;
        s_tag = 18'h777; s_set = 8'd7; s_wen = 1; s_waddr = {3'd4, 8'd7};
        s_wdata = rand_line(); saved_line = s_wdata;
        step();

        // reset arrives together with a valid request
        s_wen = 0; s_reset = 1;
        step();
        checkOutput("tp_bypass_data", l2r_data, saved_line);

        idle();
        step();
        checkOutput("tp_reset_drop", l2r_request_valid, 1'b0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            randomRequest();
            step();
        end

        idle();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
